// File: rtl/vram_console_pkg.sv
// Shared types and control-code constants for the vram_console writer.
// Holds the FSM state enum and a printable-byte classifier.
package vram_console_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLRSCR,
    CLRLINE
  } state_t;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_BLANK = 8'h20;

  function automatic logic is_print(
    input logic [7:0] b
  );
    return (b >= 8'h20) && (b != 8'h7F);
  endfunction

endpackage

// File: rtl/vram_console_if.sv
// Byte-stream valid/ready handshake into vram_console.
// master drives in_data/in_valid; slave returns in_ready.
interface vram_console_if;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/vram_console_fill.sv
// Blank-fill address generator: base+cnt for cnt=0..count-1.
// Ports: en advances, addr/data give the write, done marks the last.
module vram_fill #(
  parameter int         AW    = 11,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] count,
  output logic [AW-1:0] addr,
  output logic [7:0]    data,
  output logic          done
);

  logic [AW-1:0] cnt;

  assign addr = base + cnt;
  assign data = BLANK;
  assign done = en && (cnt == count - AW'(1));

  // Counter returns to zero after every run,
  // so the next fill always starts at base.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (done) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + AW'(1);
    end
  end

endmodule

// File: rtl/vram_console.sv
// Character-stream writer for a COLS x ROWS text VRAM with cursor.
// Ports: clk, rst_n, in_if (byte handshake), vram_waddr/wdata/we,
// cur_col/cur_row, busy. Optional: VRAM_CONSOLE_BACKSPACE_EN.
module vram_console
  import vram_console_pkg::*;
#(
  parameter int         COLS  = 40,
  parameter int         ROWS  = 30,
  parameter int         AW    = 11,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic          clk,
  input  logic          rst_n,
  vram_console_if.slave in_if,
  output logic [AW-1:0] vram_waddr,
  output logic [7:0]    vram_wdata,
  output logic          vram_we,
  output logic [5:0]    cur_col,
  output logic [4:0]    cur_row,
  output logic          busy
);

  localparam logic [AW-1:0] CELLS = AW'(COLS * ROWS);
  localparam logic [AW-1:0] LINE  = AW'(COLS);

  state_t        state, state_n;
  logic [AW-1:0] waddr_n;
  logic [7:0]    wdata_n;
  logic          we_n;
  logic [5:0]    col_n;
  logic [4:0]    row_n;
  logic [4:0]    row_inc;
  logic [7:0]    b;
  logic          accept;

  logic [AW-1:0] line_base, cell_addr;
  logic [AW-1:0] fill_base, fill_count;
  logic [AW-1:0] fill_addr;
  logic [7:0]    fill_data;
  logic          fill_en, fill_done;

  assign in_if.in_ready = (state == IDLE);
  assign accept = in_if.in_valid && in_if.in_ready;
  assign b      = in_if.in_data;

  assign line_base = AW'(cur_row) * LINE;
  assign cell_addr = line_base + AW'(cur_col);
  assign row_inc   = (cur_row == 5'(ROWS - 1)) ?
                     5'd0 : cur_row + 5'd1;

  // The cursor is stable during a fill, so
  // line_base is the newly entered row.
  assign fill_en    = (state != IDLE);
  assign fill_base  = (state == CLRLINE) ? line_base : '0;
  assign fill_count = (state == CLRLINE) ? LINE : CELLS;

  vram_fill #(
    .AW    (AW),
    .BLANK (BLANK)
  ) u_fill (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (fill_en),
    .base  (fill_base),
    .count (fill_count),
    .addr  (fill_addr),
    .data  (fill_data),
    .done  (fill_done)
  );

  always_comb begin
    state_n = state;
    we_n    = 1'b0;
    waddr_n = vram_waddr;
    wdata_n = vram_wdata;
    col_n   = cur_col;
    row_n   = cur_row;
    case (state)
      IDLE: begin
        if (accept) begin
          unique case (1'b1)
            is_print(b): begin
              we_n    = 1'b1;
              waddr_n = cell_addr;
              wdata_n = b;
              if (cur_col == 6'(COLS - 1)) begin
                col_n   = '0;
                row_n   = row_inc;
                state_n = CLRLINE;
              end else begin
                col_n = cur_col + 6'd1;
              end
            end
            (b == CH_LF): begin
              col_n   = '0;
              row_n   = row_inc;
              state_n = CLRLINE;
            end
            (b == CH_CR): col_n = '0;
            (b == CH_FF): state_n = CLRSCR;
`ifdef VRAM_CONSOLE_BACKSPACE_EN
            // Row-major layout: the cell before (r,0)
            // is (r-1,COLS-1), so both cases use -1.
            (b == CH_BS): begin
              if (cur_col != 6'd0) begin
                col_n   = cur_col - 6'd1;
                we_n    = 1'b1;
                waddr_n = cell_addr - AW'(1);
                wdata_n = BLANK;
              end else if (cur_row != 5'd0) begin
                row_n   = cur_row - 5'd1;
                col_n   = 6'(COLS - 1);
                we_n    = 1'b1;
                waddr_n = cell_addr - AW'(1);
                wdata_n = BLANK;
              end
            end
`endif
            default: ;
          endcase
        end
      end
      CLRSCR, CLRLINE: begin
        we_n    = 1'b1;
        waddr_n = fill_addr;
        wdata_n = fill_data;
        if (fill_done) begin
          state_n = IDLE;
          if (state == CLRSCR) begin
            col_n = '0;
            row_n = '0;
          end
        end
      end
      default: state_n = CLRSCR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CLRSCR;
      vram_we    <= 1'b0;
      vram_waddr <= '0;
      vram_wdata <= '0;
      cur_col    <= '0;
      cur_row    <= '0;
      busy       <= 1'b1;
    end else begin
      state      <= state_n;
      vram_we    <= we_n;
      vram_waddr <= waddr_n;
      vram_wdata <= wdata_n;
      cur_col    <= col_n;
      cur_row    <= row_n;
      busy       <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_vram_console.sv
// Self-checking bench for vram_console: directed table,
// hand sequences and random bytes against a screen model.
module tb_vram_console;

  localparam int COLS  = 40;
  localparam int ROWS  = 30;
  localparam int AW    = 11;
  localparam int CELLS = COLS * ROWS;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #20 clk = ~clk;

  vram_console_if bus();

  logic [AW-1:0] vram_waddr;
  logic [7:0]    vram_wdata;
  logic          vram_we;
  logic [5:0]    cur_col;
  logic [4:0]    cur_row;
  logic          busy;

  vram_console #(
    .COLS  (COLS),
    .ROWS  (ROWS),
    .AW    (AW),
    .BLANK (8'h20)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_if      (bus),
    .vram_waddr (vram_waddr),
    .vram_wdata (vram_wdata),
    .vram_we    (vram_we),
    .cur_col    (cur_col),
    .cur_row    (cur_row),
    .busy       (busy)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] shadow [CELLS];
  logic [7:0] mscr [CELLS];
  int mcol, mrow;
  int wq_addr[$];
  int wq_data[$];

  always @(negedge clk) begin
    if (rst_n && vram_we) begin
      if (int'(vram_waddr) < CELLS)
        shadow[vram_waddr] = vram_wdata;
      wq_addr.push_back(int'(vram_waddr));
      wq_data.push_back(int'(vram_wdata));
    end
  end

  task automatic check(input string name,
                       input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  // Reference screen model, straight from the text rules.
  task automatic m_clear();
    for (int i = 0; i < CELLS; i++) mscr[i] = 8'h20;
    mcol = 0;
    mrow = 0;
  endtask

  task automatic m_newline();
    mcol = 0;
    mrow = (mrow + 1) % ROWS;
    for (int c = 0; c < COLS; c++)
      mscr[mrow * COLS + c] = 8'h20;
  endtask

  task automatic m_apply(input logic [7:0] b);
    if (b >= 8'h20 && b != 8'h7F) begin
      mscr[mrow * COLS + mcol] = b;
      mcol++;
      if (mcol == COLS) m_newline();
    end else if (b == 8'h0A) begin
      m_newline();
    end else if (b == 8'h0D) begin
      mcol = 0;
    end else if (b == 8'h0C) begin
      m_clear();
    end
`ifdef VRAM_CONSOLE_BACKSPACE_EN
    else if (b == 8'h08) begin
      if (mcol > 0) begin
        mcol--;
        mscr[mrow * COLS + mcol] = 8'h20;
      end else if (mrow > 0) begin
        mrow--;
        mcol = COLS - 1;
        mscr[mrow * COLS + mcol] = 8'h20;
      end
    end
`endif
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!bus.in_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic send(input logic [7:0] b);
    wait_ready("send");
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    m_apply(b);
  endtask

  task automatic wait_idle();
    wait_ready("idle");
    repeat (2) @(negedge clk);
  endtask

  task automatic check_cursor(input string name);
    check({name, "_col"}, int'(cur_col), mcol);
    check({name, "_row"}, int'(cur_row), mrow);
  endtask

  task automatic check_screen(input string name);
    int bad = 0;
    for (int i = 0; i < CELLS; i++)
      if (shadow[i] !== mscr[i]) bad++;
    check({name, "_screen_bad_cells"}, bad, 0);
  endtask

  task automatic count_low(input string name, input int exp);
    int n = 0;
    while (!bus.in_ready && n < 3000) begin
      n++;
      @(negedge clk);
    end
    check({name, "_ready_low"}, n, exp);
  endtask

  task automatic check_blank_run(input string name,
                                 input int first, input int base,
                                 input int len);
    int bad = 0;
    for (int i = 0; i < len; i++) begin
      if (first + i >= wq_addr.size()) bad++;
      else if (wq_addr[first + i] != base + i ||
               wq_data[first + i] != 32'h20) bad++;
    end
    check({name, "_blank_run_bad"}, bad, 0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_we"},    int'(vram_we), 0);
    check({tag, "_busy"},  int'(busy), 1);
    check({tag, "_ready"}, int'(bus.in_ready), 0);
    check({tag, "_col"},   int'(cur_col), 0);
    check({tag, "_row"},   int'(cur_row), 0);
    check({tag, "_waddr"}, int'(vram_waddr), 0);
    check({tag, "_wdata"}, int'(vram_wdata), 0);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < CELLS; i++) shadow[i] = 8'hFF;
    wq_addr.delete();
    wq_data.delete();
    rst_n = 1'b1;
    count_low(tag, CELLS);
    repeat (2) @(negedge clk);
    check({tag, "_nwrites"}, wq_addr.size(), CELLS);
    check_blank_run(tag, 0, 0, CELLS);
    m_clear();
    check_cursor(tag);
    check({tag, "_busy_after"}, int'(busy), 0);
  endtask

  typedef struct {
    logic [7:0] b;
    int col;
    int row;
    int nwr;
    int laddr;
    int ldata;
  } vec_t;

  vec_t vt[$];
  int last;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #5;
    do_reset("reset");

    // "AB": one-cycle latency, ready stays high
    wq_addr.delete();
    wq_data.delete();
    send(8'h41);
    check("A_we", int'(vram_we), 1);
    check("A_addr", int'(vram_waddr), 0);
    check("A_data", int'(vram_wdata), 8'h41);
    check("A_ready", int'(bus.in_ready), 1);
    send(8'h42);
    check("B_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    check("B_we_one_cycle", int'(vram_we), 0);
    @(negedge clk);
    check("AB_nwr", wq_addr.size(), 2);
    check("AB_a1", wq_addr[1], 1);
    check("AB_d1", wq_data[1], 8'h42);
    check_cursor("AB");

    vt.push_back('{8'h0D, 0, 0, 0, 0, 0});
    vt.push_back('{8'h43, 1, 0, 1, 0, 8'h43});
    vt.push_back('{8'h07, 1, 0, 0, 0, 0});
    vt.push_back('{8'h7F, 1, 0, 0, 0, 0});
    vt.push_back('{8'h0A, 0, 1, 40, 79, 8'h20});
    vt.push_back('{8'hE9, 1, 1, 1, 40, 8'hE9});
`ifdef VRAM_CONSOLE_BACKSPACE_EN
    vt.push_back('{8'h08, 0, 1, 1, 40, 8'h20});
`else
    vt.push_back('{8'h08, 1, 1, 0, 0, 0});
`endif
    vt.push_back('{8'h0D, 0, 1, 0, 0, 0});
    vt.push_back('{8'h0C, 0, 0, 1200, 1199, 8'h20});
    for (int i = 0; i < vt.size(); i++) begin
      wq_addr.delete();
      wq_data.delete();
      send(vt[i].b);
      wait_idle();
      check($sformatf("vec%0d_col", i), int'(cur_col), vt[i].col);
      check($sformatf("vec%0d_row", i), int'(cur_row), vt[i].row);
      check($sformatf("vec%0d_nwr", i), wq_addr.size(), vt[i].nwr);
      if (vt[i].nwr > 0) begin
        last = wq_addr.size() - 1;
        check($sformatf("vec%0d_laddr", i), wq_addr[last], vt[i].laddr);
        check($sformatf("vec%0d_ldata", i), wq_data[last], vt[i].ldata);
      end
    end
    check_screen("table");

    // LF on the bottom row wraps to row 0 and blanks it
    for (int i = 0; i < ROWS - 1; i++) send(8'h0A);
    wait_idle();
    check("row29", int'(cur_row), 29);
    wq_addr.delete();
    wq_data.delete();
    send(8'h0A);
    count_low("wrap", COLS);
    repeat (2) @(negedge clk);
    check("wrap_nwr", wq_addr.size(), COLS);
    check_blank_run("wrap", 0, 0, COLS);
    check_cursor("wrap");

    // 40 printables from (0,5)
    for (int i = 0; i < 5; i++) send(8'h0A);
    wait_idle();
    wq_addr.delete();
    wq_data.delete();
    for (int i = 0; i < COLS; i++)
      send(8'(8'h61 + i % 26));
    wait_idle();
    check("eol_nwr", wq_addr.size(), 2 * COLS);
    check("eol_last_addr", wq_addr[COLS - 1], 239);
    check("eol_last_data", wq_data[COLS - 1], 8'h6E);
    check_blank_run("eol", COLS, 240, COLS);
    check("eol_row", int'(cur_row), 6);
    check_cursor("eol");

    // Backspace at (0,0) and at (0,3)
    send(8'h0C);
    wait_idle();
    wq_addr.delete();
    wq_data.delete();
    send(8'h08);
    wait_idle();
    check("bs00_nwr", wq_addr.size(), 0);
    check_cursor("bs00");
    for (int i = 0; i < 3; i++) send(8'h0A);
    wait_idle();
    wq_addr.delete();
    wq_data.delete();
    send(8'h08);
    wait_idle();
`ifdef VRAM_CONSOLE_BACKSPACE_EN
    check("bs03_col", int'(cur_col), 39);
    check("bs03_row", int'(cur_row), 2);
    check("bs03_nwr", wq_addr.size(), 1);
    check("bs03_addr", wq_addr[0], 119);
    check("bs03_data", wq_data[0], 8'h20);
`else
    check("bs03_col", int'(cur_col), 0);
    check("bs03_row", int'(cur_row), 3);
    check("bs03_nwr", wq_addr.size(), 0);
`endif
    check_screen("bs");

    // Random byte stream against the model
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [7:0] v;
      r = $urandom_range(0, 99);
      if (r < 70) begin
        v = 8'($urandom_range(32'h20, 32'hFF));
        if (v == 8'h7F) v = 8'h41;
      end else if (r < 80) v = 8'h0A;
      else if (r < 85) v = 8'h0D;
      else if (r < 86) v = 8'h0C;
      else if (r < 91) v = 8'h08;
      else if (r < 96) v = 8'($urandom_range(0, 31));
      else v = 8'h7F;
      send(v);
      wait_ready("rand");
      check($sformatf("rand%0d_col", i), int'(cur_col), mcol);
      check($sformatf("rand%0d_row", i), int'(cur_row), mrow);
    end
    wait_idle();
    check_screen("rand");

    // Reset in the middle of a line fill
    wq_addr.delete();
    wq_data.delete();
    send(8'h0A);
    for (int n = 0; wq_addr.size() < 10 && n < 100; n++)
      @(negedge clk);
    check("midfill_we", int'(vram_we), 1);
    check("midfill_busy", int'(busy), 1);
    do_reset("midreset");
    check_screen("midreset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
